seg7_scan: RTL and testbench
============================

# seg7_scan

Seven-segment scan driver for the timer display. It consumes the 2-bit digit-select `OE_DIGIT` from the free-running scan counter upstream and presents one of four BCD digits on the shared segment bus with its anode enabled. It inserts a dead-time blank on every digit switch to suppress ghosting. It snapshots the digit values once per scan frame so a digit never tears mid-frame.

## Interface
- `BLANK_CYCLES`, 64: clock cycles of forced blank after each `OE_DIGIT` change; legal range 0..255.
- `SEG_ACTIVE_LOW`, 1: 1 means `SEG_OUT`/`DP_OUT` lit = 0.
- `AN_ACTIVE_LOW`, 1: 1 means `AN_OUT` enabled = 0.
- `clk`  in  1  system clock, the same clock that drives the upstream scan counter.
- `rst`  in  1  asynchronous, active-high reset.
- `OE_DIGIT`  in  2  digit select from the upstream counter, synchronous to `clk`.
- `BCD_IN`  in  16  four BCD digits; `[3:0]` is digit0 (rightmost), `[15:12]` is digit3.
- `DP_IN`  in  4  decimal point per digit; bit i belongs to digit i.
- `LZB_EN`  in  1  leading-zero blanking enable.
- `SEG_OUT`  out  7  segments `{g,f,e,d,c,b,a}`.
- `DP_OUT`  out  1  decimal point segment.
- `AN_OUT`  out  4  anode enables; bit i is digit i.

## Operation
- `sel_q` is a registered copy of `OE_DIGIT`. A change is flagged on any edge where `OE_DIGIT != sel_q`, including non-adjacent jumps such as 01→11.
- On a change:
  - Load `blank_cnt` with `BLANK_CYCLES`.
  - Update `sel_q`.
- While `blank_cnt != 0`, decrement it by 1 per clock.
- The counter is reloaded on any change during blanking, which restarts the blank.
- Counter width is 8 bits.
- Frame snapshot: on a change whose new value is 2'b00, capture `BCD_IN`, `DP_IN` and `LZB_EN` into shadow registers. The shadow registers are the only source for display.
- Leading-zero blanking, evaluated from the shadow registers when shadow `LZB_EN` = 1:
  - digit3 is suppressed if its value is 0 and its DP bit is 0.
  - digit2 is suppressed if digit3 is suppressed, its value is 0 and its DP bit is 0.
  - digit1 follows the same rule, depending on digit2.
  - digit0 is never suppressed.
- A suppressed digit keeps its anode disabled for its whole slot.
- Decode:
  - Values 0–9 use the standard glyphs.
  - Values 10–15 show a dash (segment g only).
  - Active-low encodings: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, dash=0111111.
- Output states:
  - Blank: all anodes disabled, `SEG_OUT` all unlit, `DP_OUT` unlit.
  - Active: anode `sel_q` enabled, `SEG_OUT`/`DP_OUT` driven from shadow digit `sel_q`.
- All outputs are registered. Polarity is applied at the output register according to the parameters.

## Timing
- Reset (asynchronous, takes effect immediately):
  - `sel_q`=0, `blank_cnt`=0, shadow registers=0.
  - `AN_OUT`=4'b1111, `SEG_OUT`=7'b1111111, `DP_OUT`=1 (default polarities).
- After reset release with `OE_DIGIT`=00: the first edge shows shadow digit0 = "0" with `AN_OUT`=1110. Real values appear after the next entry into 00.
- The upstream counter has no reset. The bench must drive `OE_DIGIT` to a known value; `seg7_scan` does not filter X.
- A change sampled at edge k has these effects:
  - Outputs go blank at edge k, with no cycle of old-anode/new-segment overlap.
  - The new anode is enabled at edge k+`BLANK_CYCLES`.
  - Outputs are blank for exactly `BLANK_CYCLES` periods.
- `BLANK_CYCLES`=0: the anode switches at edge k with no blank.
- A snapshot taken at edge k is visible for digit0 at edge k+`BLANK_CYCLES`.
- Input changes to `BCD_IN`/`DP_IN`/`LZB_EN` have no visible effect until the next snapshot.

## Test plan
- Reset: assert `rst` mid-scan while `AN_OUT`=1101. Expected: `AN_OUT`=1111, `SEG_OUT`=1111111 and `DP_OUT`=1 immediately, without waiting for a clock edge, and held while `rst`=1.
- Scan: `BLANK_CYCLES`=4, `BCD_IN`=16'h1234, `LZB_EN`=0, `OE_DIGIT` stepped 0→1→2→3→0 every 20 cycles. Expected after each step: 4 blank cycles, then:
  - 00 → `AN_OUT`=1110, "4" (0011001), from the snapshot taken when `OE_DIGIT` returned to 00.
  - 01 → `AN_OUT`=1101, "3" (0110000).
  - 10 → `AN_OUT`=1011, "2" (0100100).
  - 11 → `AN_OUT`=0111, "1" (1111001).
- Leading zeros: `BCD_IN`=16'h0050, `LZB_EN`=1, `DP_IN`=0. Expected:
  - Slots 3 and 2 keep `AN_OUT`=1111 throughout.
  - Slot 1 shows "5".
  - Slot 0 shows "0".
  - With `DP_IN`=4'b0100, digit2 shows "0" with `DP_OUT`=0.
- Tearing: change `BCD_IN` from 16'h1234 to 16'h5678 while `OE_DIGIT`=10. Expected: slots 2 and 3 still show "2" and "1"; the new values appear only after `OE_DIGIT` next enters 00.
- Retrigger: `BLANK_CYCLES`=4, `OE_DIGIT` 00→01 then 01→10 two cycles later. Expected: blank lasts 6 cycles in total, then `AN_OUT`=1011.
- Invalid digit and zero blank: `BCD_IN`=16'h000A. Expected: digit0 shows dash 0111111. With `BLANK_CYCLES`=0, each anode switches on the same edge as the `OE_DIGIT` change.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bundle between the upstream scan counter / digit source and the seven-segment driver.
// The master side supplies digit select and frame data; the slave side drives the display pins.
interface seg7_scan_if;
  logic [1:0]  OE_DIGIT;
  logic [15:0] BCD_IN;
  logic [3:0]  DP_IN;
  logic        LZB_EN;
  logic [6:0]  SEG_OUT;
  logic        DP_OUT;
  logic [3:0]  AN_OUT;

  modport master (
    output OE_DIGIT, BCD_IN, DP_IN, LZB_EN,
    input  SEG_OUT, DP_OUT, AN_OUT
  );

  modport slave (
    input  OE_DIGIT, BCD_IN, DP_IN, LZB_EN,
    output SEG_OUT, DP_OUT, AN_OUT
  );
endinterface

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver with dead-time blanking on every digit switch,
// once-per-frame digit snapshot and optional leading-zero blanking.
module seg7_scan #(
  parameter int BLANK_CYCLES   = 64,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input logic       clk,
  input logic       rst,
  seg7_scan_if.slave bus
);

  localparam logic [7:0] BLANK_LOAD = 8'(BLANK_CYCLES);
  localparam logic [6:0] SEG_OFF    = SEG_ACTIVE_LOW ? 7'b1111111 : 7'b0000000;
  localparam logic       DP_OFF     = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF     = AN_ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [1:0]  sel_q, sel_d;
  logic [7:0]  blank_cnt, blank_d;
  logic [15:0] bcd_q, bcd_d;
  logic [3:0]  dp_q, dp_d;
  logic        lzb_q, lzb_d;
  logic        change;

  logic [3:0]  digit;
  logic        dp_bit;
  logic [3:0]  supp;
  logic        show;
  logic [6:0]  seg_lit;
  logic        dp_lit;
  logic [3:0]  an_en;
  logic [6:0]  seg_nxt;
  logic        dp_nxt;
  logic [3:0]  an_nxt;

  // Glyph table in active-low form {g,f,e,d,c,b,a}; anything above 9 is a dash.
  function automatic logic [6:0] glyph_low(input logic [3:0] v);
    case (v)
      4'd0:    glyph_low = 7'b1000000;
      4'd1:    glyph_low = 7'b1111001;
      4'd2:    glyph_low = 7'b0100100;
      4'd3:    glyph_low = 7'b0110000;
      4'd4:    glyph_low = 7'b0011001;
      4'd5:    glyph_low = 7'b0010010;
      4'd6:    glyph_low = 7'b0000010;
      4'd7:    glyph_low = 7'b1111000;
      4'd8:    glyph_low = 7'b0000000;
      4'd9:    glyph_low = 7'b0010000;
      default: glyph_low = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= 2'b00;
      blank_cnt <= 8'd0;
      bcd_q     <= 16'h0000;
      dp_q      <= 4'h0;
      lzb_q     <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      blank_cnt <= blank_d;
      bcd_q     <= bcd_d;
      dp_q      <= dp_d;
      lzb_q     <= lzb_d;
    end
  end

  // A new digit select restarts the dead time; entering slot 0 begins a new frame.
  always_comb begin
    change  = (bus.OE_DIGIT != sel_q);
    sel_d   = bus.OE_DIGIT;
    blank_d = blank_cnt;
    bcd_d   = bcd_q;
    dp_d    = dp_q;
    lzb_d   = lzb_q;
    if (change) begin
      blank_d = BLANK_LOAD;
    end else if (blank_cnt != 8'd0) begin
      blank_d = blank_cnt - 8'd1;
    end
    if (change && (bus.OE_DIGIT == 2'b00)) begin
      bcd_d = bus.BCD_IN;
      dp_d  = bus.DP_IN;
      lzb_d = bus.LZB_EN;
    end
  end

  // Outputs are derived from next-state values so the output register lines up with the state.
  always_comb begin
    digit   = bcd_d[{sel_d, 2'b00} +: 4];
    dp_bit  = dp_d[sel_d];
    supp[3] = lzb_d && (bcd_d[15:12] == 4'd0) && !dp_d[3];
    supp[2] = supp[3] && (bcd_d[11:8] == 4'd0) && !dp_d[2];
    supp[1] = supp[2] && (bcd_d[7:4] == 4'd0) && !dp_d[1];
    supp[0] = 1'b0;
    show    = (blank_d == 8'd0) && !supp[sel_d];
    seg_lit = show ? ~glyph_low(digit) : 7'b0000000;
    dp_lit  = show && dp_bit;
    an_en   = show ? (4'b0001 << sel_d) : 4'b0000;
    seg_nxt = SEG_ACTIVE_LOW ? ~seg_lit : seg_lit;
    dp_nxt  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
    an_nxt  = AN_ACTIVE_LOW ? ~an_en : an_en;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.SEG_OUT <= SEG_OFF;
      bus.DP_OUT  <= DP_OFF;
      bus.AN_OUT  <= AN_OFF;
    end else begin
      bus.SEG_OUT <= seg_nxt;
      bus.DP_OUT  <= dp_nxt;
      bus.AN_OUT  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan: two instances (4-cycle blank and zero blank) share clock and reset;
// stimulus pushes per-cycle expected display states, a negedge monitor pops and compares them.
module tb_seg7_scan;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GD = 7'b0111111;
  localparam logic [6:0] SOFF = 7'b1111111;
  localparam logic [3:0] AOFF = 4'b1111;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t q4[$];
  exp_t q0[$];

  seg7_scan_if bus4 ();
  seg7_scan_if bus0 ();

  seg7_scan #(.BLANK_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  seg7_scan #(.BLANK_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectRange(input int which, input int from, input int upto,
                             input logic [3:0] an, input logic [6:0] seg, input logic dp,
                             input string name);
    exp_t e;
    for (int c = from; c <= upto; c++) begin
      e.cyc  = c;
      e.an   = an;
      e.seg  = seg;
      e.dp   = dp;
      e.name = name;
      if (which == 0) q4.push_back(e);
      else            q0.push_back(e);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] bcd, input logic [3:0] dp, input logic lzb);
    bus4.BCD_IN = bcd;
    bus4.DP_IN  = dp;
    bus4.LZB_EN = lzb;
  endtask

  // Switch the 4-cycle instance to a new slot and hold it for 20 cycles.
  task automatic stepDigit(input logic [1:0] oe, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp, input string name);
    bus4.OE_DIGIT = oe;
    expectRange(0, cyc + 1, cyc + 4, AOFF, SOFF, 1'b1, {name, "_blank"});
    expectRange(0, cyc + 5, cyc + 20, an, seg, dp, name);
    waitCycles(20);
  endtask

  task automatic checkOutput(input exp_t e, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp);
    checks++;
    if (an !== e.an || seg !== e.seg || dp !== e.dp) begin
      errors++;
      $display("[TB] FAIL %s cyc %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               e.name, cyc, an, seg, dp, e.an, e.seg, e.dp);
    end
  endtask

  // Monitor: stale entries mean a check was scheduled for a cycle that already passed.
  always @(negedge clk) begin
    while (q4.size() > 0 && q4[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL stale_%s cyc %0d: entry for cycle %0d not compared", q4[0].name, cyc, q4[0].cyc);
      void'(q4.pop_front());
    end
    while (q4.size() > 0 && q4[0].cyc == cyc) begin
      checkOutput(q4[0], bus4.AN_OUT, bus4.SEG_OUT, bus4.DP_OUT);
      void'(q4.pop_front());
    end
    while (q0.size() > 0 && q0[0].cyc < cyc) begin
      checks++;
      errors++;
      $display("[TB] FAIL stale_%s cyc %0d: entry for cycle %0d not compared", q0[0].name, cyc, q0[0].cyc);
      void'(q0.pop_front());
    end
    while (q0.size() > 0 && q0[0].cyc == cyc) begin
      checkOutput(q0[0], bus0.AN_OUT, bus0.SEG_OUT, bus0.DP_OUT);
      void'(q0.pop_front());
    end
  end

  initial begin
    int t;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus4.OE_DIGIT = 2'b00;
    bus4.BCD_IN   = 16'h0000;
    bus4.DP_IN    = 4'h0;
    bus4.LZB_EN   = 1'b0;
    bus0.OE_DIGIT = 2'b00;
    bus0.BCD_IN   = 16'h0000;
    bus0.DP_IN    = 4'h0;
    bus0.LZB_EN   = 1'b0;

    waitCycles(3);
    expectRange(0, cyc, cyc + 1, AOFF, SOFF, 1'b1, "reset_hold");
    expectRange(1, cyc, cyc + 1, AOFF, SOFF, 1'b1, "reset_hold0");
    waitCycles(2);
    rst = 1'b0;
    expectRange(0, cyc + 1, cyc + 2, 4'b1110, G0, 1'b1, "post_reset_d0");
    expectRange(1, cyc + 1, cyc + 2, 4'b1110, G0, 1'b1, "post_reset0_d0");
    waitCycles(2);

    $display("[TB] scan with 1234, first frame still shows reset snapshot");
    applyStimulus(16'h1234, 4'h0, 1'b0);
    stepDigit(2'd1, 4'b1101, G0, 1'b1, "scanA_d1");
    stepDigit(2'd2, 4'b1011, G0, 1'b1, "scanA_d2");
    stepDigit(2'd3, 4'b0111, G0, 1'b1, "scanA_d3");
    stepDigit(2'd0, 4'b1110, G4, 1'b1, "scanA_d0");
    stepDigit(2'd1, 4'b1101, G3, 1'b1, "scanB_d1");
    stepDigit(2'd2, 4'b1011, G2, 1'b1, "scanB_d2");

    $display("[TB] tearing: new data mid-frame");
    applyStimulus(16'h5678, 4'h0, 1'b0);
    stepDigit(2'd3, 4'b0111, G1, 1'b1, "tear_d3_old");
    stepDigit(2'd0, 4'b1110, G8, 1'b1, "tear_d0_new");
    stepDigit(2'd1, 4'b1101, G7, 1'b1, "tear_d1_new");
    stepDigit(2'd2, 4'b1011, G6, 1'b1, "tear_d2_new");
    stepDigit(2'd3, 4'b0111, G5, 1'b1, "tear_d3_new");

    $display("[TB] leading-zero blanking");
    applyStimulus(16'h0050, 4'h0, 1'b1);
    stepDigit(2'd0, 4'b1110, G0, 1'b1, "lzb_d0");
    stepDigit(2'd1, 4'b1101, G5, 1'b1, "lzb_d1");
    stepDigit(2'd2, AOFF, SOFF, 1'b1, "lzb_d2_supp");
    stepDigit(2'd3, AOFF, SOFF, 1'b1, "lzb_d3_supp");
    applyStimulus(16'h0050, 4'b0100, 1'b1);
    stepDigit(2'd0, 4'b1110, G0, 1'b1, "lzbdp_d0");
    stepDigit(2'd1, 4'b1101, G5, 1'b1, "lzbdp_d1");
    stepDigit(2'd2, 4'b1011, G0, 1'b0, "lzbdp_d2_dp");
    stepDigit(2'd3, AOFF, SOFF, 1'b1, "lzbdp_d3_supp");
    stepDigit(2'd0, 4'b1110, G0, 1'b1, "lzbdp_d0b");

    $display("[TB] retrigger during blank");
    t = cyc;
    bus4.OE_DIGIT = 2'd1;
    expectRange(0, t + 1, t + 6, AOFF, SOFF, 1'b1, "retrig_blank");
    expectRange(0, t + 7, t + 12, 4'b1011, G0, 1'b0, "retrig_d2");
    waitCycles(2);
    bus4.OE_DIGIT = 2'd2;
    waitCycles(10);

    $display("[TB] asynchronous reset mid-scan");
    t = cyc;
    bus4.OE_DIGIT = 2'd1;
    expectRange(0, t + 1, t + 4, AOFF, SOFF, 1'b1, "prerst_blank");
    expectRange(0, t + 5, t + 7, 4'b1101, G5, 1'b1, "prerst_d1");
    waitCycles(8);
    #1;
    rst = 1'b1;
    expectRange(0, t + 8, t + 10, AOFF, SOFF, 1'b1, "async_reset");
    waitCycles(2);
    rst = 1'b0;
    expectRange(0, t + 11, t + 14, AOFF, SOFF, 1'b1, "postrst_blank");
    expectRange(0, t + 15, t + 18, 4'b1101, G0, 1'b1, "postrst_d1_cleared");
    waitCycles(8);

    $display("[TB] zero blank and invalid digit");
    t = cyc;
    expectRange(1, t, t, 4'b1110, G0, 1'b1, "zb_before");
    bus0.BCD_IN   = 16'h000A;
    bus0.OE_DIGIT = 2'd1;
    expectRange(1, t + 1, t + 3, 4'b1101, G0, 1'b1, "zb_d1_same_edge");
    waitCycles(3);
    bus0.OE_DIGIT = 2'd0;
    expectRange(1, t + 4, t + 6, 4'b1110, GD, 1'b1, "zb_d0_dash");
    waitCycles(3);
    bus0.OE_DIGIT = 2'd2;
    expectRange(1, t + 7, t + 9, 4'b1011, G0, 1'b1, "zb_d2");
    waitCycles(3);

    for (int i = 0; i < 50 && (q4.size() > 0 || q0.size() > 0); i++) @(posedge clk);
    if (q4.size() > 0 || q0.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", q4.size() + q0.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
